// File: rtl/stopwatch_digits.sv
// BCD stopwatch HH:MM:SS.hh feeding an 8-digit display controller.
// Optional lap feature (LAP state, snapshot, display mux) is built when STOPWATCH_LAP_EN is defined.
module stopwatch_digits #(
    parameter int CLKFREQ  = 100_000_000,
    parameter int TICKFREQ = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] d7,
    output logic [3:0] d6,
    output logic [3:0] d5,
    output logic [3:0] d4,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       dp7,
    output logic       dp6,
    output logic       dp5,
    output logic       dp4,
    output logic       dp3,
    output logic       dp2,
    output logic       dp1,
    output logic       dp0,
    output logic       running,
    output logic       ovf,
    output logic [1:0] state_dbg
);

    localparam int DIV = CLKFREQ / TICKFREQ;
    localparam int DW  = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    // Per-digit terminal values, d7 in the top nibble: hours 99, minutes 59, seconds 59, hundredths 99.
    localparam logic [31:0] LIMITS = 32'h9959_5999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    // Control inputs are single-cycle pulses with no handshake; priority is
    // clear over start_stop over lap, and the losers of a collision are dropped.
    state_t         state_q;
    logic [DW-1:0]  div_q;
    logic [31:0]    cnt_q;
    logic [31:0]    cnt_inc;
    logic [31:0]    disp;
    logic           ovf_q;
    logic           carry;
    logic           wrap;
    logic           counting;
    logic           tick;

    always_comb begin
        cnt_inc = cnt_q;
        carry   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (carry) begin
                if (cnt_q[4*i +: 4] == LIMITS[4*i +: 4]) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        // A carry out of d7 means every digit rolled over to zero.
        wrap = carry;
    end

`ifdef STOPWATCH_LAP_EN
    logic [31:0] snap_q;
    assign counting = (state_q == RUN) || (state_q == LAP);
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign counting   = (state_q == RUN);
`endif

    assign tick = counting && (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            snap_q  <= '0;
`endif
        end else if (clear) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (tick) begin
                cnt_q <= cnt_inc;
                if (wrap) begin
                    ovf_q <= 1'b1;
                end
            end

            if (counting) begin
                div_q <= tick ? '0 : div_q + 1'b1;
            end else begin
                div_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (start_stop) state_q <= RUN;
                end
                RUN: begin
                    if (start_stop) begin
                        state_q <= PAUSE;
                        div_q   <= '0;
                    end
`ifdef STOPWATCH_LAP_EN
                    else if (lap) begin
                        state_q <= LAP;
                        snap_q  <= cnt_q;
                    end
`endif
                end
`ifdef STOPWATCH_LAP_EN
                LAP: begin
                    if (start_stop) begin
                        state_q <= PAUSE;
                        div_q   <= '0;
                    end else if (lap) begin
                        state_q <= RUN;
                    end
                end
`endif
                PAUSE: begin
                    if (start_stop) state_q <= RUN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef STOPWATCH_LAP_EN
    assign disp = (state_q == LAP) ? snap_q : cnt_q;
`else
    assign disp = cnt_q;
`endif

    assign {d7, d6, d5, d4, d3, d2, d1, d0} = disp;

    assign dp7 = 1'b0;
    assign dp6 = 1'b1;
    assign dp5 = 1'b0;
    assign dp4 = 1'b1;
    assign dp3 = 1'b0;
    assign dp2 = 1'b1;
    assign dp1 = 1'b0;
    assign dp0 = 1'b0;

    assign running   = counting;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_digits.sv
// Directed bench for stopwatch_digits at DIV=10; expectations follow STOPWATCH_LAP_EN when defined.
module tb_stopwatch_digits;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] d7, d6, d5, d4, d3, d2, d1, d0;
    logic       dp7, dp6, dp5, dp4, dp3, dp2, dp1, dp0;
    logic       running;
    logic       ovf;
    logic [1:0] state_dbg;

    int checks_total  = 0;
    int checks_passed = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_LAP   = 2'd3;

    stopwatch_digits #(.CLKFREQ(10), .TICKFREQ(1)) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
        .d7(d7), .d6(d6), .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .dp7(dp7), .dp6(dp6), .dp5(dp5), .dp4(dp4), .dp3(dp3), .dp2(dp2), .dp1(dp1), .dp0(dp0),
        .running(running), .ovf(ovf), .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    function automatic logic [31:0] disp();
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Driver tasks: inputs change on the falling edge; each call advances to the next falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic c, input logic l);
        start_stop = s;
        clear      = c;
        lap        = l;
        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        step(2);
        reset = 1'b0;

        // Reset state after a long idle stretch
        step(50);
        check("reset_time", disp(), 32'h0);
        check("reset_running", running, 0);
        check("reset_ovf", ovf, 0);
        check("reset_dp", {dp7, dp6, dp5, dp4, dp3, dp2, dp1, dp0}, 8'b0101_0100);
        check("reset_state", state_dbg, S_IDLE);

        // First interval after start is a full DIV cycles
        pulse(1, 0, 0);
        check("start_running", running, 1);
        check("start_state", state_dbg, S_RUN);
        step(9);
        check("before_first_tick", disp(), 32'h0);
        step(1);
        check("first_tick", disp(), 32'h1);
        step(9);
        check("before_second_tick", disp(), 32'h1);
        step(1);
        check("second_tick", disp(), 32'h2);

        // Pause holds the value
        step(4);
        pulse(1, 0, 0);
        check("pause_running", running, 0);
        check("pause_state", state_dbg, S_PAUSE);
        step(100);
        check("pause_hold", disp(), 32'h2);

        // Resume restarts a full interval, then pause on the tick cycle keeps that tick
        pulse(1, 0, 0);
        step(9);
        check("resume_before_tick", disp(), 32'h2);
        step(1);
        check("resume_tick", disp(), 32'h3);
        step(9);
        pulse(1, 0, 0);
        check("pause_on_tick_value", disp(), 32'h4);
        check("pause_on_tick_running", running, 0);
        step(30);
        check("pause_on_tick_hold", disp(), 32'h4);

        pulse(0, 1, 0);
        check("clear_from_pause", disp(), 32'h0);
        check("clear_state", state_dbg, S_IDLE);

        // 5999 ticks reach 00:00:59.99, one more carries into minutes
        pulse(1, 0, 0);
        step(59990);
        check("preload_5999", disp(), 32'h0000_5999);
        step(10);
        check("carry_to_minutes", disp(), 32'h0001_0000);

        // clear beats start_stop while running
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        step(50);
        check("run_to_05", disp(), 32'h5);
        pulse(1, 1, 0);
        check("clear_ss_time", disp(), 32'h0);
        check("clear_ss_running", running, 0);
        check("clear_ss_state", state_dbg, S_IDLE);
        step(20);
        check("clear_ss_stays_idle", disp(), 32'h0);

        // Wrap past 99:59:59.99 from a forced preload while idle
        force dut.cnt_q = 32'h9959_5999;
        step(1);
        release dut.cnt_q;
        step(1);
        check("wrap_preload", disp(), 32'h9959_5999);
        pulse(1, 0, 0);
        step(9);
        check("wrap_before", disp(), 32'h9959_5999);
        check("wrap_before_ovf", ovf, 0);
        step(1);
        check("wrap_time", disp(), 32'h0);
        check("wrap_ovf", ovf, 1);
        step(10);
        check("ovf_sticky_time", disp(), 32'h1);
        check("ovf_sticky", ovf, 1);
        pulse(0, 1, 0);
        check("clear_ovf", ovf, 0);
        check("clear_ovf_running", running, 0);

        // Lap freeze / unfreeze
        pulse(1, 0, 0);
        step(30);
        check("lap_pre", disp(), 32'h3);
        pulse(0, 0, 1);
        step(50);
        check("lap_running", running, 1);
`ifdef STOPWATCH_LAP_EN
        check("lap_frozen", disp(), 32'h3);
        check("lap_state", state_dbg, S_LAP);
`else
        check("lap_ignored", disp(), 32'h8);
        check("lap_state", state_dbg, S_RUN);
`endif
        pulse(0, 0, 1);
        check("lap_release", disp(), 32'h8);
        check("lap_release_state", state_dbg, S_RUN);

        // Lap on a tick cycle snapshots the pre-increment value
        step(7);
        pulse(0, 0, 1);
`ifdef STOPWATCH_LAP_EN
        check("lap_on_tick", disp(), 32'h8);
`else
        check("lap_on_tick", disp(), 32'h9);
`endif
        pulse(1, 0, 0);
        check("lap_to_pause_live", disp(), 32'h9);
        check("lap_to_pause_state", state_dbg, S_PAUSE);
        pulse(0, 0, 1);
        check("lap_in_pause_ignored", state_dbg, S_PAUSE);
        check("lap_in_pause_value", disp(), 32'h9);

        // Reset mid-run
        pulse(1, 0, 0);
        step(15);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("reset_midrun_time", disp(), 32'h0);
        check("reset_midrun_running", running, 0);
        step(20);
        check("reset_midrun_idle", disp(), 32'h0);

        // Final report
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/stopwatch_digits.md
# stopwatch_digits

Upstream source for the 8-digit display controller: a BCD stopwatch that counts HH:MM:SS.hh from an internal tick divider. It presents eight 4-bit digit values plus eight active-high decimal-point enables, ready to wire straight into the display controller's `d7..d0` / `dp7..dp0` inputs. Control comes from single-cycle pulses on start/stop, clear and lap, produced by upstream debouncers.

## Interface
- `CLKFREQ`, 100_000_000: system clock frequency in Hz.
- `TICKFREQ`, 100: count rate in Hz (one hundredth of a second).
  - `DIV = CLKFREQ/TICKFREQ`, integer division; `DIV` must be ≥ 2.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start_stop`  in  1  one-cycle pulse; toggles run/pause.
- `clear`  in  1  one-cycle pulse; zeroes the time and stops counting.
- `lap`  in  1  one-cycle pulse; freezes or unfreezes the displayed value (see Configuration).
- `d7..d0`  out  4 each  BCD digits:
  - `d7:d6` hours 00–99.
  - `d5:d4` minutes 00–59.
  - `d3:d2` seconds 00–59.
  - `d1:d0` hundredths 00–99.
- `dp7..dp0`  out  1 each  active-high decimal points.
  - `dp6`, `dp4`, `dp2` = 1 (separators).
  - All other decimal points = 0.
- `running`  out  1  high in RUN and LAP states.
- `ovf`  out  1  sticky; set on wrap past 99:59:59.99.

## Operation
- Time register: eight BCD digits, each always 0–9.
  - Tens digits `d5` and `d3` are bounded 0–5.
- Increment on tick uses a ripple-carry chain from `d0` upward:
  - `d0` 9→0 carries into `d1`; `d1` 9→0 carries into `d2`.
  - `d2` 9→0 carries into `d3`; `d3` 5→0 carries into `d4`.
  - `d4` 9→0 carries into `d5`; `d5` 5→0 carries into `d6`.
  - `d6` 9→0 carries into `d7`; `d7` 9→0 wraps the whole register to all-zero and sets `ovf`.
- Divider: counts 0..DIV-1 only in RUN/LAP.
  - Tick = divider at DIV-1.
  - Divider is forced to 0 in IDLE and PAUSE. Every start therefore gives a full DIV-cycle first interval.
- State machine: IDLE, RUN, PAUSE, LAP. Transitions:
  - IDLE: `start_stop` → RUN.
  - RUN: `start_stop` → PAUSE; `lap` → LAP.
  - LAP: `start_stop` → PAUSE (display goes live); `lap` → RUN.
  - PAUSE: `start_stop` → RUN, resuming from the held time.
  - Any state: `clear` → IDLE with time zeroed, divider zeroed and `ovf` cleared.
- Priority on simultaneous pulses: `clear` > `start_stop` > `lap`. The lower-priority pulses are ignored.
- `lap` in IDLE or PAUSE: ignored.
- Display mux:
  - In LAP, `d7..d0` come from a snapshot register, loaded with the live time in the cycle `lap` is accepted from RUN.
  - In all other states the outputs show the live time.
  - Counting continues underneath while in LAP.

## Timing
- Reset values:
  - state IDLE.
  - All digits 0 and snapshot 0.
  - Divider 0, `running` 0, `ovf` 0.
  - `dp` pattern constant (`dp6`/`dp4`/`dp2` = 1).
- All outputs are registered or derived from registers only. There is no combinational path from inputs to outputs.
- `start_stop` sampled at edge of cycle N (from IDLE/PAUSE):
  - `running` = 1 from N+1.
  - Divider = 0 at N+1 and reaches DIV-1 at N+DIV.
  - First increment is visible at N+DIV+1.
  - Subsequent increments come every DIV cycles.
- Pause: a `start_stop` accepted in the same cycle as a tick still applies that tick. The final time includes it.
- Lap snapshot: captures the register value present in the cycle `lap` is sampled.
  - If a tick coincides, the snapshot holds the pre-increment value.
- `clear` sampled in cycle N: digits, `ovf` and `running` read 0 at N+1, including mid-count.
- `reset` has the same effect as `clear`, plus it resets the snapshot register.

## Configuration
- Macro `STOPWATCH_LAP_EN` selects the lap feature:
  - Defined: LAP state, snapshot register and display mux are present, as described above.
  - Undefined:
    - LAP state and snapshot register are not built.
    - `lap` port remains but is ignored.
    - `d7..d0` always show the live time.
    - `running` is high only in RUN.

## Test plan
All scenarios use `CLKFREQ=10`, `TICKFREQ=1` (DIV=10).
- Reset, then 50 idle cycles → all digits 0, `running`=0, `ovf`=0, `dp6`/`dp4`/`dp2`=1, other dps 0.
- `start_stop` at cycle 0 → `d0` reads 1 at cycle 11 and 2 at cycle 21. A second `start_stop` at cycle 25 holds `d0`=2 for 100 cycles.
- Preload via 5999 ticks (00:00:59.99), then one more tick → 00:01:00.00.
  - Separately, from 99:59:59.99 one tick → all zero with `ovf`=1.
- `clear` and `start_stop` in the same cycle while RUN at 00:00:00.05 → next cycle IDLE, all zero, `running`=0.
- With `STOPWATCH_LAP_EN`: `lap` at time 00:00:00.03, run 50 more cycles → display stays .03. A second `lap` → display jumps to .08.
- Without `STOPWATCH_LAP_EN`: same stimulus → display tracks live time throughout.
